// File: rtl/axis_frame_generator_pkg.sv
// Shared types and helpers for the AXI-Stream frame generator.
package axis_frame_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } gen_state_t;

  // TDATA of a given beat; callers truncate to their TDATA width, which gives the wrap.
  function automatic logic [63:0] next_tdata(input logic [63:0] seed, input logic [63:0] beat);
    return seed + beat;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle with master/slave views; widths are set by the parameters.
interface axis_if #(
  parameter int TDATA_W = 8,
  parameter int TID_W   = 4,
  parameter int TDEST_W = 4,
  parameter int TUSER_W = 1
);
  localparam int TKEEP_W = (TDATA_W + 7) / 8;

  logic               tvalid;
  logic               tready;
  logic [TDATA_W-1:0] tdata;
  logic [TKEEP_W-1:0] tkeep;
  logic [TKEEP_W-1:0] tstrb;
  logic               tlast;
  logic [TID_W-1:0]   tid;
  logic [TDEST_W-1:0] tdest;
  logic [TUSER_W-1:0] tuser;
  logic               twakeup;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
    output tready
  );
endinterface

// File: rtl/axis_frame_generator.sv
// AXI-Stream transmitter: frames of programmable length with incrementing TDATA,
// optional abort and a programmable inter-frame gap.
module axis_frame_generator
  import axis_frame_generator_pkg::*;
#(
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int IFG_CYCLES = 0,
  parameter int TDATA_W    = 8,
  parameter int TID_W      = 4,
  parameter int TDEST_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic [TDATA_W-1:0]   seed,
  input  logic [TID_W-1:0]     tid,
  input  logic [TDEST_W-1:0]   tdest,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] frame_count,
  output gen_state_t           dbg_state,
  axis_if.master               out_axis_if
);

  localparam int GAP_W = $clog2(IFG_CYCLES + 2);

  // Stream handshake: a beat transfers on a rising edge where tvalid & tready are both
  // high; once tvalid rises it stays high and the payload stays unchanged until then.

  gen_state_t           state_q, state_d;
  logic [LEN_WIDTH-1:0] beat_q;
  logic [LEN_WIDTH-1:0] last_beat_q;
  logic [TDATA_W-1:0]   seed_q;
  logic [TID_W-1:0]     tid_q;
  logic [TDEST_W-1:0]   tdest_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 done_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic sending;
  logic handshake;
  logic is_last;

  assign sending   = (state_q == SEND);
  assign handshake = sending && out_axis_if.tready;
  assign is_last   = (beat_q == last_beat_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) state_d = SEND;
      end
      SEND: begin
        if (handshake && is_last) state_d = (IFG_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: captured frame parameters, beat/gap counters, done pulse and frame counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q      <= '0;
      last_beat_q <= '0;
      seed_q      <= '0;
      tid_q       <= '0;
      tdest_q     <= '0;
      gap_q       <= '0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (frame_len != '0) begin
              beat_q      <= '0;
              last_beat_q <= frame_len - LEN_WIDTH'(1);
              seed_q      <= seed;
              tid_q       <= tid;
              tdest_q     <= tdest;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (handshake) begin
            if (is_last) begin
              done_q  <= 1'b1;
              count_q <= count_q + CNT_WIDTH'(1);
              gap_q   <= GAP_W'(IFG_CYCLES - 1);
            end else begin
              beat_q <= beat_q + LEN_WIDTH'(1);
            end
          end
          // Abort shortens the frame so the beat after the one on the bus is the last.
          if (abort && !is_last) last_beat_q <= beat_q + LEN_WIDTH'(1);
        end
        GAP: begin
          if (gap_q != '0) gap_q <= gap_q - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    out_axis_if.tvalid  = sending;
    out_axis_if.tdata   = sending ? TDATA_W'(next_tdata(64'(seed_q), 64'(beat_q))) : '0;
    out_axis_if.tkeep   = '1;
    out_axis_if.tstrb   = '1;
    out_axis_if.tlast   = sending && is_last;
    out_axis_if.tid     = sending ? tid_q : '0;
    out_axis_if.tdest   = sending ? tdest_q : '0;
    out_axis_if.tuser   = '0;
    out_axis_if.twakeup = 1'b0;
    busy                = (state_q != IDLE);
    done                = done_q;
    frame_count         = count_q;
    dbg_state           = state_q;
  end

endmodule

// File: tb/tb_axis_frame_generator.sv
// Self-checking bench for axis_frame_generator: vector table, random frames against a
// frame-level model, reset/abort sequences and inter-frame gap measurement.
module tb_axis_frame_generator;
  import axis_frame_generator_pkg::*;

  localparam int W = 21;  // {tlast, tid, tdest, tdata, tkeep, tstrb, tuser, twakeup}

  typedef struct {
    logic [15:0] len;
    logic [7:0]  seed;
    int          abort_at;   // beat index on the bus when abort is raised, -1 = none
    int          mode;       // 0 tready=1, 1 random tready, 2 stall in the abort cycle
    int          exp_beats;
    logic [7:0]  exp_last;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start = 1'b0;
  logic        start_g = 1'b0;
  logic [15:0] frame_len = '0;
  logic [7:0]  seed = '0;
  logic [3:0]  tid = '0;
  logic [3:0]  tdest = '0;
  logic        abort = 1'b0;
  logic        tready = 1'b1;
  logic        g_tready = 1'b1;
  logic        busy, done, busy_g, done_g;
  logic [31:0] frame_count, frame_count_g;
  gen_state_t  dbg_state, dbg_state_g;

  axis_if #(.TDATA_W(8), .TID_W(4), .TDEST_W(4), .TUSER_W(1)) m_if ();
  axis_if #(.TDATA_W(8), .TID_W(4), .TDEST_W(4), .TUSER_W(1)) g_if ();
  assign m_if.tready = tready;
  assign g_if.tready = g_tready;

  axis_frame_generator #(
    .LEN_WIDTH(16), .CNT_WIDTH(32), .IFG_CYCLES(0), .TDATA_W(8), .TID_W(4), .TDEST_W(4)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len), .seed(seed),
    .tid(tid), .tdest(tdest), .abort(abort), .busy(busy), .done(done),
    .frame_count(frame_count), .dbg_state(dbg_state), .out_axis_if(m_if)
  );

  axis_frame_generator #(
    .LEN_WIDTH(16), .CNT_WIDTH(32), .IFG_CYCLES(3), .TDATA_W(8), .TID_W(4), .TDEST_W(4)
  ) u_gap (
    .clk(clk), .reset(reset), .start(start_g), .frame_len(frame_len), .seed(seed),
    .tid(tid), .tdest(tdest), .abort(1'b0), .busy(busy_g), .done(done_g),
    .frame_count(frame_count_g), .dbg_state(dbg_state_g), .out_axis_if(g_if)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int exp_count = 0;
  bit sb_en = 1'b1;
  int hs_frame = 0;
  int valid_cycles = 0;
  int done_cnt = 0;
  logic [7:0] last_data = '0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_payload = '0;

  function automatic logic [W-1:0] bus_payload();
    return {m_if.tlast, m_if.tid, m_if.tdest, m_if.tdata,
            m_if.tkeep, m_if.tstrb, m_if.tuser, m_if.twakeup};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: a frame is len beats of seed+i; an abort raised while beat p is on
  // the bus (and p is not already the last) makes beat p+1 the final one.
  task automatic model_frame(input int len, input logic [7:0] sd, input logic [3:0] id,
                             input logic [3:0] dst, input int abort_at);
    int n;
    logic [7:0] d;
    n = len;
    if (abort_at >= 0 && abort_at + 1 < len) n = abort_at + 2;
    for (int i = 0; i < n; i++) begin
      d = 8'(int'(sd) + i);
      exp_q.push_back({(i == n - 1), id, dst, d, 1'b1, 1'b1, 1'b0, 1'b0});
    end
  endtask

  // Monitor: samples at the falling edge, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      got = bus_payload();
      if (prev_stall) begin
        total++;
        if (!m_if.tvalid || got !== prev_payload) begin
          bad++;
          $display("FAIL stall_hold got=%0h/%0b exp=%0h/1", got, m_if.tvalid, prev_payload);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        hs_frame++;
        last_data = m_if.tdata;
        if (sb_en) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat got=%0h exp=none", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              bad++;
              $display("FAIL beat got=%0h exp=%0h", got, exp);
            end
          end
        end
      end
      if (m_if.tvalid) valid_cycles++;
      if (done) done_cnt++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_payload = got;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_vec(input vec_t v);
    bit a_done;
    logic [3:0] id, dst;
    a_done = 1'b0;
    id = 4'($urandom_range(0, 15));
    dst = 4'($urandom_range(0, 15));
    model_frame(int'(v.len), v.seed, id, dst, v.abort_at);
    if (v.len != 0) exp_count++;
    hs_frame = 0; valid_cycles = 0; done_cnt = 0; last_data = '0;
    frame_len = v.len; seed = v.seed; tid = id; tdest = dst;
    start = 1'b1; tready = 1'b1;
    abort = 1'b1;  // abort in IDLE must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    frame_len = 16'($urandom); seed = 8'($urandom); tid = 4'($urandom); tdest = 4'($urandom);
    for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
      tready = (v.mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      abort = 1'b0;
      if (v.abort_at >= 0 && !a_done && hs_frame == v.abort_at) begin
        abort = 1'b1;
        a_done = 1'b1;
        if (v.mode == 2) tready = 1'b0;
      end
      start = (hs_frame == 1 && v.exp_beats > 2);  // start while busy is ignored
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0; tready = 1'b1;
    repeat (2) @(negedge clk);
    check("beats", 32'(hs_frame), 32'(v.exp_beats));
    if (v.exp_beats > 0) check("last_tdata", 32'(last_data), 32'(v.exp_last));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("frame_count", frame_count, 32'(exp_count));
    check("busy_after", 32'(busy), 32'd0);
    if (v.mode == 0) check("no_bubbles", 32'(valid_cycles), 32'(v.exp_beats));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Counts TVALID-low cycles between a TLAST handshake and the next TVALID, and how many
  // of those cycles the generator reported busy (the forced gap).
  task automatic measure_gap(input bit use_gap, output int idle, output int gap_busy,
                             output bit ok);
    int st;
    logic v, l, b;
    st = 0; idle = 0; gap_busy = 0; ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      v = use_gap ? g_if.tvalid : m_if.tvalid;
      l = use_gap ? g_if.tlast : m_if.tlast;
      b = use_gap ? busy_g : busy;
      if (st == 0) begin
        if (v && l) st = 1;
      end else begin
        if (v) begin
          ok = 1'b1;
          break;
        end
        idle++;
        if (b) gap_busy++;
      end
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[9];

  initial begin
    vec_t rv;
    int idle, gbusy;
    bit ok;

    vecs[0] = '{16'd1,      8'h5A, -1, 0, 1, 8'h5A};
    vecs[1] = '{16'd4,      8'hFE, -1, 0, 4, 8'h01};
    vecs[2] = '{16'd8,      8'h10, -1, 0, 8, 8'h17};
    vecs[3] = '{16'd8,      8'h30, -1, 1, 8, 8'h37};
    vecs[4] = '{16'd100,    8'h00,  3, 0, 5, 8'h04};
    vecs[5] = '{16'd100,    8'h80,  3, 2, 5, 8'h84};
    vecs[6] = '{16'd2,      8'hC0,  1, 0, 2, 8'hC1};
    vecs[7] = '{16'd0,      8'h00, -1, 0, 0, 8'h00};
    vecs[8] = '{16'hFFFF,   8'h20,  2, 0, 4, 8'h23};

    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_tlast", 32'(m_if.tlast), 32'd0);
    check("rst_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", frame_count, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    for (int i = 0; i < 15; i++) begin
      rv.len = 16'($urandom_range(1, 24));
      rv.seed = 8'($urandom);
      rv.abort_at = -1;
      rv.mode = 1;
      rv.exp_beats = int'(rv.len);
      rv.exp_last = 8'(int'(rv.seed) + int'(rv.len) - 1);
      run_vec(rv);
    end

    // Reset in the middle of a frame drops it at once
    sb_en = 1'b0;
    frame_len = 16'd50; seed = 8'h44; start = 1'b1; tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("midrst_tlast", 32'(m_if.tlast), 32'd0);
    check("midrst_tdata", 32'(m_if.tdata), 32'd0);
    check("midrst_count", frame_count, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_count = 0;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    sb_en = 1'b1;
    rv = '{16'd6, 8'h11, -1, 0, 6, 8'h16};
    run_vec(rv);

    // Back-to-back frames with start held: no gap beyond the start latency
    sb_en = 1'b0;
    frame_len = 16'd3; seed = 8'h00; tready = 1'b1; start = 1'b1;
    measure_gap(1'b0, idle, gbusy, ok);
    check("b2b_seen", 32'(ok), 32'd1);
    check("b2b_idle", 32'(idle), 32'd1);
    check("b2b_gap_busy", 32'(gbusy), 32'd0);
    start = 1'b0;

    // IFG_CYCLES=3: three forced gap cycles, plus the IDLE cycle that accepts start
    start_g = 1'b1;
    for (int k = 0; k < 2; k++) begin
      measure_gap(1'b1, idle, gbusy, ok);
      check("ifg_seen", 32'(ok), 32'd1);
      check("ifg_gap_cycles", 32'(gbusy), 32'd3);
      check("ifg_idle", 32'(idle), 32'd4);
    end
    start_g = 1'b0;
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
